// File: rtl/imm_gen_stage.sv
// Immediate-generation decode stage: classifies RV32/RV64 instruction format
// and registers the extended immediate behind a valid/ready skid buffer.
module imm_gen_stage #(
   parameter int XLEN    = 32,
   parameter bit SKID_EN = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal,
   output logic [31:0]     out_inst,
   output logic [XLEN-1:0] out_pc
);

   localparam logic [2:0] F_R     = 3'd0;
   localparam logic [2:0] F_I     = 3'd1;
   localparam logic [2:0] F_S     = 3'd2;
   localparam logic [2:0] F_B     = 3'd3;
   localparam logic [2:0] F_U     = 3'd4;
   localparam logic [2:0] F_J     = 3'd5;
   localparam logic [2:0] F_SHAMT = 3'd6;
   localparam logic [2:0] F_NONE  = 3'd7;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            ill;
      logic [31:0]     inst;
      logic [XLEN-1:0] pc;
   } ent_t;

   state_t state, state_n;
   ent_t   main_q, skid_q, dec;

   logic        in_fire, out_fire;
   logic        load_main, load_skid, skid_to_main;
   logic [6:0]  op;
   logic        is_sh;
   logic        use_sh;
   logic [5:0]  shamt;
   logic [31:0] imm32;
   logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

   assign op    = in_inst[6:0];
   assign is_sh = (in_inst[13:12] == 2'b01);
   assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
   assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign imm_b = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
   assign imm_j = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20],
                   in_inst[30:21], 1'b0};
   assign imm_u = {in_inst[31:12], 12'h000};

   // funct3 001/101 are the only values with [13:12] == 01
   always_comb begin
      imm32  = '0;
      shamt  = '0;
      use_sh = 1'b0;
      dec    = '0;
      dec.fmt = F_NONE;
      dec.ill = 1'b0;
      case (op)
         7'b0010011: begin
            if (is_sh) begin
               dec.fmt = F_SHAMT;
               use_sh  = 1'b1;
               shamt   = (XLEN == 64) ? in_inst[25:20]
                                      : {1'b0, in_inst[24:20]};
            end else begin
               dec.fmt = F_I;
               imm32   = imm_i;
            end
         end
         7'b0000011, 7'b1100111: begin
            dec.fmt = F_I;
            imm32   = imm_i;
         end
         7'b0100011: begin
            dec.fmt = F_S;
            imm32   = imm_s;
         end
         7'b1100011: begin
            dec.fmt = F_B;
            imm32   = imm_b;
         end
         7'b1101111: begin
            dec.fmt = F_J;
            imm32   = imm_j;
         end
         7'b0110111, 7'b0010111: begin
            dec.fmt = F_U;
            imm32   = imm_u;
         end
         7'b0110011, 7'b1110011, 7'b0001111: begin
            dec.fmt = F_R;
         end
         7'b0011011: begin
            if (XLEN != 64) begin
               dec.ill = 1'b1;
            end else if (is_sh) begin
               dec.fmt = F_SHAMT;
               use_sh  = 1'b1;
               shamt   = {1'b0, in_inst[24:20]};
            end else begin
               dec.fmt = F_I;
               imm32   = imm_i;
            end
         end
         default: dec.ill = 1'b1;
      endcase
      dec.imm  = use_sh ? XLEN'(shamt) : XLEN'($signed(imm32));
      dec.inst = in_inst;
      dec.pc   = in_pc;
   end

   assign out_valid = (state != EMPTY);
   assign in_ready  = ~reset & (SKID_EN ? (state != FULL)
                                        : (out_ready | ~out_valid));
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      state_n      = state;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      unique case (state)
         EMPTY: begin
            if (in_fire) begin
               state_n   = ONE;
               load_main = 1'b1;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               load_main = 1'b1;
            end else if (in_fire) begin
               state_n   = FULL;
               load_skid = 1'b1;
            end else if (out_fire) begin
               state_n = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               state_n      = ONE;
               skid_to_main = 1'b1;
            end
         end
         default: state_n = EMPTY;
      endcase
      if (flush) begin
         state_n      = EMPTY;
         load_main    = 1'b0;
         load_skid    = 1'b0;
         skid_to_main = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state <= state_n;
         if (skid_to_main)   main_q <= skid_q;
         else if (load_main) main_q <= dec;
         if (load_skid)      skid_q <= dec;
      end
   end

   assign out_imm     = main_q.imm;
   assign out_fmt     = main_q.fmt;
   assign out_illegal = main_q.ill;
   assign out_inst    = main_q.inst;
   assign out_pc      = main_q.pc;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: directed vectors plus a randomized run
// against a 2-deep FIFO reference model, on XLEN=32 and XLEN=64 copies.
module tb_imm_gen_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_inst = '0;
   logic [63:0] pc = '0;

   logic        ir32, ov32, ill32;
   logic [31:0] imm32, inst32, pc32;
   logic [2:0]  fmt32;
   logic        ir64, ov64, ill64;
   logic [63:0] imm64, pc64;
   logic [31:0] inst64;
   logic [2:0]  fmt64;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   imm_gen_stage #(.XLEN(32), .SKID_EN(1'b1)) dut32 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(ir32),
      .in_inst(in_inst), .in_pc(pc[31:0]),
      .out_valid(ov32), .out_ready(out_ready),
      .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32),
      .out_inst(inst32), .out_pc(pc32)
   );

   imm_gen_stage #(.XLEN(64), .SKID_EN(1'b1)) dut64 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(ir64),
      .in_inst(in_inst), .in_pc(pc),
      .out_valid(ov64), .out_ready(out_ready),
      .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64),
      .out_inst(inst64), .out_pc(pc64)
   );

   typedef struct {
      logic [31:0] inst;
      logic [63:0] pc;
   } ent_t;

   // Reference decode built from the instruction-set field definitions.
   function automatic void model(input logic [31:0] i, input bit x64,
                                 output logic [63:0] imm,
                                 output logic [2:0] fmt, output bit ill);
      int unsigned f3;
      bit sh;
      f3  = i[14:12];
      sh  = (f3 == 1) || (f3 == 5);
      imm = 64'd0;
      fmt = 3'd7;
      ill = 1'b1;
      case (i[6:0])
         7'h13: begin
            ill = 0;
            if (sh) begin
               fmt = 6;
               imm = x64 ? 64'(i[25:20]) : 64'(i[24:20]);
            end else begin
               fmt = 1;
               imm = longint'(int'(i) >>> 20);
            end
         end
         7'h03, 7'h67: begin
            ill = 0; fmt = 1; imm = longint'(int'(i) >>> 20);
         end
         7'h23: begin
            ill = 0; fmt = 2;
            imm = longint'(((int'(i) >>> 25) * 32) + int'(i[11:7]));
         end
         7'h63: begin
            ill = 0; fmt = 3;
            imm = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
         end
         7'h6F: begin
            ill = 0; fmt = 5;
            imm = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
         end
         7'h37, 7'h17: begin
            ill = 0; fmt = 4;
            imm = longint'(int'(i & 32'hFFFF_F000));
         end
         7'h33, 7'h73, 7'h0F: begin
            ill = 0; fmt = 0;
         end
         7'h1B: begin
            if (x64) begin
               ill = 0;
               if (sh) begin
                  fmt = 6; imm = 64'(i[24:20]);
               end else begin
                  fmt = 1; imm = longint'(int'(i) >>> 20);
               end
            end
         end
         default: ;
      endcase
   endfunction

   task automatic drive(input logic rst, input logic v, input logic [31:0] i,
                        input logic rdy, input logic fl);
      @(negedge clk);
      reset     = rst;
      in_valid  = v;
      in_inst   = i;
      out_ready = rdy;
      flush     = fl;
      pc        = {$urandom(), $urandom()};
      #1;
   endtask

   task automatic test_reset;
      drive(1, 0, 0, 1, 0);
      n_vec++; if (ir32 !== 1'b0) begin n_err++; $display("FAIL rst_ready got %0b exp 0", ir32); end
      drive(1, 0, 0, 1, 0);
      n_vec++; if (ov32 !== 1'b0 || ov64 !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b/%0b exp 0", ov32, ov64); end
      n_vec++; if (imm32 !== 0 || fmt32 !== 0 || ill32 !== 0 || inst32 !== 0 || pc32 !== 0) begin
         n_err++; $display("FAIL rst_payload imm %h fmt %0d ill %0b inst %h pc %h exp all 0", imm32, fmt32, ill32, inst32, pc32);
      end
      drive(0, 0, 0, 1, 0);
      n_vec++; if (ir32 !== 1'b1 || ov32 !== 1'b0) begin n_err++; $display("FAIL rst_release ready %0b valid %0b exp 1/0", ir32, ov32); end
   endtask

   task automatic test_basic;
      drive(0, 1, 32'hFFF00093, 1, 0);
      n_vec++; if (ir32 !== 1'b1) begin n_err++; $display("FAIL addi_ready got %0b exp 1", ir32); end
      drive(0, 1, 32'h4030D093, 1, 0);
      n_vec++; if (ov32 !== 1 || imm32 !== 32'hFFFFFFFF || fmt32 !== 3'd1) begin
         n_err++; $display("FAIL addi v %0b imm %h fmt %0d exp 1 ffffffff 1", ov32, imm32, fmt32);
      end
      n_vec++; if (imm64 !== 64'hFFFFFFFF_FFFFFFFF) begin n_err++; $display("FAIL addi64 imm %h exp all ones", imm64); end
      drive(0, 0, 0, 1, 0);
      n_vec++; if (ov32 !== 1 || imm32 !== 32'd3 || fmt32 !== 3'd6) begin
         n_err++; $display("FAIL srai v %0b imm %h fmt %0d exp 1 3 6", ov32, imm32, fmt32);
      end
      drive(0, 0, 0, 1, 0);
      n_vec++; if (ov32 !== 1'b0) begin n_err++; $display("FAIL basic_drain valid %0b exp 0", ov32); end
   endtask

   task automatic test_sequence;
      drive(0, 1, 32'h123452B7, 1, 0);
      drive(0, 1, 32'hFE000EE3, 1, 0);
      n_vec++; if (ov32 !== 1 || imm32 !== 32'h12345000 || fmt32 !== 3'd4) begin
         n_err++; $display("FAIL lui v %0b imm %h fmt %0d exp 1 12345000 4", ov32, imm32, fmt32);
      end
      drive(0, 1, 32'hFF9FF06F, 1, 0);
      n_vec++; if (ov32 !== 1 || imm32 !== 32'hFFFFFFFC || fmt32 !== 3'd3) begin
         n_err++; $display("FAIL beq v %0b imm %h fmt %0d exp 1 fffffffc 3", ov32, imm32, fmt32);
      end
      drive(0, 1, 32'h00000000, 1, 0);
      n_vec++; if (ov32 !== 1 || imm32 !== 32'hFFFFFFF8 || fmt32 !== 3'd5) begin
         n_err++; $display("FAIL jal v %0b imm %h fmt %0d exp 1 fffffff8 5", ov32, imm32, fmt32);
      end
      drive(0, 0, 0, 1, 0);
      n_vec++; if (ov32 !== 1 || imm32 !== 0 || fmt32 !== 3'd7 || ill32 !== 1) begin
         n_err++; $display("FAIL zero_inst v %0b imm %h fmt %0d ill %0b exp 1 0 7 1", ov32, imm32, fmt32, ill32);
      end
      drive(0, 0, 0, 1, 0);
   endtask

   task automatic test_backpressure;
      drive(0, 1, 32'h00500113, 0, 0);
      drive(0, 1, 32'hFE112E23, 0, 0);
      n_vec++; if (ir32 !== 1 || ov32 !== 1 || imm32 !== 32'd5) begin
         n_err++; $display("FAIL bp_one ready %0b v %0b imm %h exp 1 1 5", ir32, ov32, imm32);
      end
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 32'h00000013, 0, 0);
         n_vec++; if (ir32 !== 0 || ov32 !== 1 || imm32 !== 32'd5 || inst32 !== 32'h00500113) begin
            n_err++; $display("FAIL bp_full ready %0b v %0b imm %h inst %h exp 0 1 5 00500113", ir32, ov32, imm32, inst32);
         end
      end
      drive(0, 0, 0, 1, 0);
      n_vec++; if (ov32 !== 1 || imm32 !== 32'd5) begin n_err++; $display("FAIL bp_first v %0b imm %h exp 1 5", ov32, imm32); end
      drive(0, 0, 0, 1, 0);
      n_vec++; if (ov32 !== 1 || imm32 !== 32'hFFFFFFFC || fmt32 !== 3'd2 || ir32 !== 1) begin
         n_err++; $display("FAIL bp_second v %0b imm %h fmt %0d rdy %0b exp 1 fffffffc 2 1", ov32, imm32, fmt32, ir32);
      end
      drive(0, 0, 0, 1, 0);
      n_vec++; if (ov32 !== 1'b0) begin n_err++; $display("FAIL bp_drain valid %0b exp 0", ov32); end
   endtask

   task automatic test_flush;
      drive(0, 1, 32'h00500113, 0, 0);
      drive(0, 1, 32'hFE112E23, 0, 0);
      drive(0, 1, 32'h00700193, 0, 1);
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 1, 0);
         n_vec++; if (ov32 !== 1'b0 || ov64 !== 1'b0 || ir32 !== 1'b1) begin
            n_err++; $display("FAIL flush_%0d valid %0b/%0b ready %0b exp 0/0 1", k, ov32, ov64, ir32);
         end
      end
   endtask

   task automatic test_reset_full;
      drive(0, 1, 32'h00500113, 0, 0);
      drive(0, 1, 32'hFE112E23, 0, 0);
      drive(1, 1, 32'h00700193, 0, 0);
      n_vec++; if (ir32 !== 1'b0) begin n_err++; $display("FAIL rstfull_ready got %0b exp 0", ir32); end
      drive(1, 0, 0, 1, 0);
      n_vec++; if (ov32 !== 0 || imm32 !== 0 || fmt32 !== 0 || inst32 !== 0 || pc32 !== 0 || ir32 !== 0) begin
         n_err++; $display("FAIL rstfull_out v %0b imm %h fmt %0d inst %h pc %h rdy %0b exp all 0", ov32, imm32, fmt32, inst32, pc32, ir32);
      end
      drive(0, 0, 0, 1, 0);
      n_vec++; if (ir32 !== 1'b1 || ov32 !== 1'b0) begin n_err++; $display("FAIL rstfull_after ready %0b valid %0b exp 1/0", ir32, ov32); end
      drive(0, 0, 0, 1, 0);
      n_vec++; if (ov32 !== 1'b0) begin n_err++; $display("FAIL rstfull_noemerge valid %0b exp 0", ov32); end
   endtask

   task automatic test_xlen64;
      drive(0, 1, 32'h02009093, 1, 0);
      drive(0, 0, 0, 1, 0);
      n_vec++; if (ov64 !== 1 || imm64 !== 64'd32 || fmt64 !== 3'd6) begin
         n_err++; $display("FAIL slli64 v %0b imm %h fmt %0d exp 1 32 6", ov64, imm64, fmt64);
      end
      n_vec++; if (imm32 !== 32'd0 || fmt32 !== 3'd6) begin
         n_err++; $display("FAIL slli32 imm %h fmt %0d exp 0 6", imm32, fmt32);
      end
      drive(0, 0, 0, 1, 0);
   endtask

   task automatic test_random;
      ent_t        q[$];
      ent_t        e;
      logic [6:0]  ops[12];
      logic [31:0] r, ri;
      logic [63:0] x_imm;
      logic [2:0]  x_fmt;
      bit          x_ill;
      bit          v, rdy, fl, infire, outfire;
      ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F,
              7'h37, 7'h17, 7'h33, 7'h1B, 7'h0F, 7'h00};
      for (int c = 0; c < 600; c++) begin
         r   = $urandom();
         ri  = $urandom();
         v   = r[0] | r[1];
         rdy = r[2] ^ r[5] ? 1'b1 : r[3];
         fl  = (r[11:6] == 6'd0);
         if (r[15:12] == 4'd11) ri[6:0] = r[22:16];
         else ri[6:0] = ops[r[15:12] % 11];
         drive(0, v, ri, rdy, fl);
         n_vec++; if (ov32 !== (q.size() != 0) || ov64 !== (q.size() != 0)) begin
            n_err++; $display("FAIL rnd_valid c%0d got %0b/%0b exp %0b", c, ov32, ov64, q.size() != 0);
         end
         n_vec++; if (ir32 !== (q.size() < 2) || ir64 !== (q.size() < 2)) begin
            n_err++; $display("FAIL rnd_ready c%0d got %0b/%0b exp %0b", c, ir32, ir64, q.size() < 2);
         end
         if (q.size() != 0) begin
            e = q[0];
            model(e.inst, 1'b0, x_imm, x_fmt, x_ill);
            n_vec++; if (imm32 !== x_imm[31:0] || fmt32 !== x_fmt || ill32 !== x_ill || inst32 !== e.inst || pc32 !== e.pc[31:0]) begin
               n_err++; $display("FAIL rnd32 c%0d inst %h imm %h fmt %0d ill %0b pc %h exp inst %h imm %h fmt %0d ill %0b pc %h",
                                 c, inst32, imm32, fmt32, ill32, pc32, e.inst, x_imm[31:0], x_fmt, x_ill, e.pc[31:0]);
            end
            model(e.inst, 1'b1, x_imm, x_fmt, x_ill);
            n_vec++; if (imm64 !== x_imm || fmt64 !== x_fmt || ill64 !== x_ill || inst64 !== e.inst || pc64 !== e.pc) begin
               n_err++; $display("FAIL rnd64 c%0d inst %h imm %h fmt %0d ill %0b pc %h exp inst %h imm %h fmt %0d ill %0b pc %h",
                                 c, inst64, imm64, fmt64, ill64, pc64, e.inst, x_imm, x_fmt, x_ill, e.pc);
            end
         end
         infire  = v && (q.size() < 2);
         outfire = rdy && (q.size() != 0);
         if (fl) begin
            q.delete();
         end else begin
            if (outfire) void'(q.pop_front());
            if (infire) q.push_back('{inst: ri, pc: pc});
         end
      end
      drive(0, 0, 0, 1, 1);
      drive(0, 0, 0, 1, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sequence();
      test_backpressure();
      test_flush();
      test_reset_full();
      test_xlen64();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
